// File: rtl/water_level_encoder.sv
// water_level_encoder: debounced float-switch thermometer encoder; define WATER_LEVEL_STICKY_ERROR_EN for a sticky error flag
module water_level_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sensors,
  input  logic       error_clear,
  output logic [1:0] data,
  output logic       error,
  output logic       valid,
  output logic       changed
);
  typedef enum logic [1:0] {WAIT, HOLD, SETTLE} state_t;
  localparam logic [CNT_WIDTH-1:0] DB = CNT_WIDTH'(DEBOUNCE_CYCLES);
`ifdef WATER_LEVEL_STICKY_ERROR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  if (DEBOUNCE_CYCLES < 1 || longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_WIDTH) - 1) begin : g_bad_cfg
    $error("water_level_encoder: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end
  state_t state, state_n;
  logic [2:0] meta, s, p, p_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [1:0] data_n;
  logic error_n, valid_n, changed_n, commit;
  function automatic logic legal(input logic [2:0] v);
    return v == 3'b000 || v == 3'b001 || v == 3'b011 || v == 3'b111;
  endfunction
  function automatic logic [1:0] enc(input logic [2:0] v);
    return v[2] ? 2'b11 : v[1] ? 2'b10 : v[0] ? 2'b01 : 2'b00;
  endfunction
  // meta is the value S takes at this edge, s is S as last registered (the candidate C_q)
  always_comb begin
    cnt_n = (meta != s) ? CNT_WIDTH'(1) : (cnt == DB ? cnt : cnt + CNT_WIDTH'(1));
    commit = cnt_n == DB && (state == WAIT || meta != p);
    state_n = state;
    p_n = p;
    data_n = data;
    error_n = error;
    valid_n = valid;
    if (commit) begin
      state_n = HOLD;
      p_n = meta;
      valid_n = 1'b1;
      data_n = legal(meta) ? enc(meta) : data;
      error_n = ~legal(meta) | (STICKY & error);
    end else if (state != WAIT) begin
      state_n = (meta != p) ? SETTLE : HOLD;
      error_n = (STICKY && error_clear && legal(p)) ? 1'b0 : error;
    end
    changed_n = (commit && state == WAIT) || data_n != data || error_n != error;
  end
  // synchroniser, debounce counter, FSM and committed outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      s <= '0;
      cnt <= '0;
      state <= WAIT;
      p <= '0;
      data <= '0;
      error <= 1'b0;
      valid <= 1'b0;
      changed <= 1'b0;
    end else begin
      meta <= sensors;
      s <= meta;
      cnt <= cnt_n;
      state <= state_n;
      p <= p_n;
      data <= data_n;
      error <= error_n;
      valid <= valid_n;
      changed <= changed_n;
    end
  end
endmodule
